leitor_matriculas_invalidas: RTL and testbench
==============================================

Name: leitor_matriculas_invalidas

Overview:
- Read-side counterpart of the invalid-plate store. Takes the two stored invalid plates (24-bit, 6 hex digits each; 24'h0 means an empty slot) and streams them out one 4-bit digit at a time over a valid/ready handshake, oldest slot first.
- Feeds the display or serial front-end that shows the invalid-plate log on operator request.
- Snapshots both slots at request time, so updates to the store during a readout do not corrupt the stream.

Parameters:
- DIGITOS, 6, hex digits per plate; plate width = 4*DIGITOS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Matricula1  in  4*DIGITOS  older stored invalid plate; 0 = empty.
- Matricula2  in  4*DIGITOS  newer stored invalid plate; 0 = empty.
- pedido  in  1  readout request, sampled only in IDLE.
- pronto_saida  in  1  sink ready.
- digito  out  4  current digit, MSB nibble first.
- digito_valido  out  1  digito is valid.
- indice  out  1  slot of current digit: 0 = Matricula1, 1 = Matricula2.
- posicao  out  3  digit index within plate, 0 = most significant.
- ultimo  out  1  current digit is the last one of its plate.
- ocupado  out  1  readout in progress.
- fim  out  1  one-cycle pulse: readout complete.
- vazio  out  1  one-cycle pulse: request found both slots empty.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (async assert, sync release): state IDLE; snapshot registers cleared; digito=0, digito_valido=0, indice=0, posicao=0, ultimo=0, ocupado=0, fim=0, vazio=0.
- A reset mid-readout aborts the readout. No fim pulse is produced. A new pedido is required to restart.
- FSM states: IDLE, ENVIA, FIM, VAZIO.
- IDLE, pedido=1 at edge k:
  - Capture Matricula1 into snap1 and Matricula2 into snap2.
  - Set ocupado=1.
  - If snap1 != 0: go to ENVIA with indice=0, posicao=0.
  - Else if snap2 != 0: go to ENVIA with indice=1, posicao=0.
  - Else: go to VAZIO.
  - digito_valido is first high in the cycle after edge k (latency 1).
- ENVIA:
  - digito = nibble[DIGITOS-1-posicao] of the selected snapshot.
  - ultimo = (posicao == DIGITOS-1).
  - A transfer occurs on each edge where digito_valido=1 and pronto_saida=1.
  - Without a transfer, digito, indice and posicao hold stable.
  - Transfer with posicao < DIGITOS-1: posicao+1.
  - Transfer with posicao = DIGITOS-1 and indice=0 and snap2 != 0: indice=1, posicao=0.
  - Any other final-digit transfer: go to FIM, digito_valido=0.
- FIM: fim=1 for exactly one cycle; then ocupado=0; go to IDLE.
- VAZIO: vazio=1 for exactly one cycle; digito_valido stays 0; then ocupado=0; go to IDLE.
- pedido while not in IDLE is ignored (no queuing).
- Throughput: 1 digit/cycle with pronto_saida held high. Two full plates = 2*DIGITOS transfers; fim is high in the cycle after the last transfer.
- Input changes on Matricula1/2 after capture have no effect until the next pedido.
- posicao never exceeds DIGITOS-1. indice never returns from 1 to 0 within a readout.

Test Plan:
- Matricula1=24'h12AB34, Matricula2=24'h56CD78, pronto_saida=1, pedido pulse at edge 0 -> digits 1,2,A,B,3,4 (indice 0) on edges 1–6, then 5,6,C,D,7,8 (indice 1) on edges 7–12. ultimo high on the digits 4 and 8. fim high for one cycle after edge 12. ocupado low afterwards.
- Matricula1=0, Matricula2=24'h0F0F0F -> 6 digits 0,F,0,F,0,F, all indice=1, then fim. Matricula1=24'hABCDEF, Matricula2=0 -> 6 digits, indice=0, then fim.
- Both slots 0, pedido -> vazio high exactly one cycle; digito_valido never asserts; fim stays 0.
- Backpressure: first case, with pronto_saida=0 for 3 cycles while digito=A (posicao=2) -> digito=A, posicao=2, digito_valido=1 held stable for those cycles; stream resumes with B, no digit lost or duplicated.
- Snapshot and ignore: change Matricula1 to 24'h999999 after the 2nd transfer, and pulse pedido again mid-stream -> output remains 1,2,A,B,3,4,5,6,C,D,7,8; exactly one fim.
- Reset: assert rst_n=0 after the 4th transfer -> all outputs 0 immediately (asynchronous); after release, no activity until pedido; a new pedido restarts from digit 1 at posicao=0.

Source files
------------

// File: rtl/leitor_matriculas_invalidas.sv
// Read-side streamer for the invalid-plate store: snapshots both stored
// plates on request and sends them out one hex digit at a time, oldest slot
// first, over a valid/ready handshake. An all-zero plate is an empty slot.
//
// state | meaning
// IDLE  | waiting for pedido; snapshot registers hold the last capture
// ENVIA | streaming digits of the selected snapshot
// FIM   | one-cycle completion pulse, then back to IDLE
// VAZIO | request found both slots empty; one-cycle pulse, then IDLE
`timescale 1ns/1ps
module leitor_matriculas_invalidas #(
  parameter int DIGITOS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*DIGITOS-1:0]   Matricula1,
  input  logic [4*DIGITOS-1:0]   Matricula2,
  input  logic                   pedido,
  input  logic                   pronto_saida,
  output logic [3:0]             digito,
  output logic                   digito_valido,
  output logic                   indice,
  output logic [2:0]             posicao,
  output logic                   ultimo,
  output logic                   ocupado,
  output logic                   fim,
  output logic                   vazio
);

  localparam int             LARGURA   = 4 * DIGITOS;
  localparam logic [2:0]     LP_ULTIMA = 3'(DIGITOS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENVIA = 2'd1,
    FIM   = 2'd2,
    VAZIO = 2'd3
  } estado_t;

  estado_t              r_estado;
  estado_t              w_prox_estado;
  logic [LARGURA-1:0]   r_snap1;
  logic [LARGURA-1:0]   r_snap2;
  logic [LARGURA-1:0]   w_snap1_prox;
  logic [LARGURA-1:0]   w_snap2_prox;
  logic                 r_indice;
  logic                 w_indice_prox;
  logic [2:0]           r_posicao;
  logic [2:0]           w_posicao_prox;
  logic [LARGURA-1:0]   w_sel;
  logic [3:0]           w_nibble;
  logic                 w_envia;
  logic                 w_transfer;
  logic                 w_ultimo;

  assign w_envia    = (r_estado == ENVIA);
  assign w_transfer = w_envia && pronto_saida;
  assign w_ultimo   = (r_posicao == LP_ULTIMA);

  // State and datapath registers; reset aborts any readout in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= IDLE;
      r_snap1   <= '0;
      r_snap2   <= '0;
      r_indice  <= 1'b0;
      r_posicao <= 3'd0;
    end else begin
      r_estado  <= w_prox_estado;
      r_snap1   <= w_snap1_prox;
      r_snap2   <= w_snap2_prox;
      r_indice  <= w_indice_prox;
      r_posicao <= w_posicao_prox;
    end
  end

  // Next-state logic: capture on request, advance digit/slot on each transfer.
  always_comb begin
    w_prox_estado  = r_estado;
    w_snap1_prox   = r_snap1;
    w_snap2_prox   = r_snap2;
    w_indice_prox  = r_indice;
    w_posicao_prox = r_posicao;
    case (r_estado)
      IDLE: begin
        if (pedido) begin
          w_snap1_prox   = Matricula1;
          w_snap2_prox   = Matricula2;
          w_posicao_prox = 3'd0;
          if (Matricula1 != '0) begin
            w_prox_estado = ENVIA;
            w_indice_prox = 1'b0;
          end else if (Matricula2 != '0) begin
            w_prox_estado = ENVIA;
            w_indice_prox = 1'b1;
          end else begin
            w_prox_estado = VAZIO;
            w_indice_prox = 1'b0;
          end
        end
      end
      ENVIA: begin
        if (w_transfer) begin
          if (!w_ultimo) begin
            w_posicao_prox = r_posicao + 3'd1;
          end else if (!r_indice && (r_snap2 != '0)) begin
            // Older plate done and the newer slot holds a plate: continue there.
            w_indice_prox  = 1'b1;
            w_posicao_prox = 3'd0;
          end else begin
            w_prox_estado = FIM;
          end
        end
      end
      FIM:     w_prox_estado = IDLE;
      VAZIO:   w_prox_estado = IDLE;
      default: w_prox_estado = IDLE;
    endcase
  end

  // Digit select: posicao 0 addresses the most significant nibble.
  always_comb begin
    w_sel    = r_indice ? r_snap2 : r_snap1;
    w_nibble = 4'd0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (r_posicao == 3'(i)) begin
        w_nibble = w_sel[4*(DIGITOS-1-i) +: 4];
      end
    end
  end

  // Outputs decode from the state so an async reset clears them immediately.
  always_comb begin
    digito        = w_envia ? w_nibble : 4'd0;
    digito_valido = w_envia;
    indice        = r_indice;
    posicao       = r_posicao;
    ultimo        = w_envia && w_ultimo;
    ocupado       = (r_estado != IDLE);
    fim           = (r_estado == FIM);
    vazio         = (r_estado == VAZIO);
  end

endmodule

// File: tb/tb_leitor_matriculas_invalidas.sv
// Bench for the invalid-plate streamer: expected digits are queued when a
// request is issued and compared as the DUT hands each digit over.
`timescale 1ns/1ps
module tb_leitor_matriculas_invalidas;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] Matricula1, Matricula2;
  logic        pedido, pronto_saida;
  logic [3:0]  digito;
  logic        digito_valido, indice, ultimo, ocupado, fim, vazio;
  logic [2:0]  posicao;

  leitor_matriculas_invalidas #(.DIGITOS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .Matricula1(Matricula1), .Matricula2(Matricula2),
    .pedido(pedido), .pronto_saida(pronto_saida),
    .digito(digito), .digito_valido(digito_valido), .indice(indice),
    .posicao(posicao), .ultimo(ultimo), .ocupado(ocupado),
    .fim(fim), .vazio(vazio)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_xfer = 0;
  int fim_cnt = 0;
  int vazio_cnt = 0;
  logic [8:0] q_esp[$];
  logic [8:0] e;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_vec++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard side: a digit is consumed when valid and ready meet.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_esp.delete();
    end else begin
      if (digito_valido && pronto_saida) begin
        if (q_esp.size() == 0) begin
          verifica("unexpected_digit", 32'd1, 32'd0);
        end else begin
          e = q_esp.pop_front();
          verifica("digit", {23'd0, indice, posicao, digito, ultimo}, {23'd0, e});
        end
        last_xfer = cyc;
      end
      if (fim) begin
        fim_cnt++;
        verifica("fim_latency", 32'(cyc - last_xfer), 32'd1);
      end
      if (vazio) begin
        vazio_cnt++;
        verifica("vazio_no_valid", {31'd0, digito_valido}, 32'd0);
      end
    end
  end

  task automatic empilha(input logic [23:0] p, input logic idx);
    for (int i = 0; i < 6; i++) begin
      q_esp.push_back({idx, 3'(i), p[4*(5-i) +: 4], (i == 5)});
    end
  endtask

  task automatic empilha_par(input logic [23:0] m1, input logic [23:0] m2);
    if (m1 != 24'd0) empilha(m1, 1'b0);
    if (m2 != 24'd0) empilha(m2, 1'b1);
  endtask

  // Called at #1 after an edge; returns at #1 after the sampling edge.
  task automatic pulso_pedido();
    pedido = 1'b1;
    @(posedge clk); #1;
    pedido = 1'b0;
  endtask

  task automatic espera_idle(input string tag);
    int n = 0;
    while (ocupado && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (ocupado) verifica(tag, 32'd1, 32'd0);
  endtask

  task automatic espera_pos(input logic idx, input logic [2:0] pos, input string tag);
    int n = 0;
    while (!(digito_valido && indice == idx && posicao == pos) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(digito_valido && indice == idx && posicao == pos)) verifica(tag, 32'd0, 32'd1);
  endtask

  task automatic leitura(input logic [23:0] m1, input logic [23:0] m2, input string tag);
    int base_fim, base_vazio;
    base_fim   = fim_cnt;
    base_vazio = vazio_cnt;
    Matricula1 = m1;
    Matricula2 = m2;
    empilha_par(m1, m2);
    pulso_pedido();
    verifica({tag, "_latency"}, {31'd0, digito_valido}, {31'd0, ((m1 | m2) != 24'd0)});
    verifica({tag, "_ocupado"}, {31'd0, ocupado}, 32'd1);
    espera_idle({tag, "_timeout"});
    @(posedge clk); #1;
    verifica({tag, "_fim_count"}, 32'(fim_cnt - base_fim), {31'd0, ((m1 | m2) != 24'd0)});
    verifica({tag, "_vazio_count"}, 32'(vazio_cnt - base_vazio), {31'd0, ((m1 | m2) == 24'd0)});
    verifica({tag, "_drain"}, 32'(q_esp.size()), 32'd0);
  endtask

  initial begin
    int base_fim;
    rst_n = 1'b0; pedido = 1'b0; pronto_saida = 1'b1;
    Matricula1 = 24'h12AB34; Matricula2 = 24'h56CD78;
    repeat (2) @(posedge clk);
    #1;
    verifica("reset_outputs",
             {20'd0, digito, digito_valido, indice, posicao, ultimo, ocupado, fim, vazio}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    verifica("idle_no_request", {31'd0, ocupado}, 32'd0);

    leitura(24'h12AB34, 24'h56CD78, "two_plates");
    leitura(24'h000000, 24'h0F0F0F, "slot2_only");
    leitura(24'hABCDEF, 24'h000000, "slot1_only");
    leitura(24'h000000, 24'h000000, "both_empty");

    // Backpressure while digit A is presented.
    base_fim = fim_cnt;
    Matricula1 = 24'h12AB34; Matricula2 = 24'h56CD78;
    empilha_par(Matricula1, Matricula2);
    pulso_pedido();
    espera_pos(1'b0, 3'd2, "bp_reach_timeout");
    pronto_saida = 1'b0;
    for (int i = 0; i < 3; i++) begin
      verifica("bp_hold", {24'd0, digito, posicao, digito_valido}, {24'd0, 4'hA, 3'd2, 1'b1});
      @(posedge clk); #1;
    end
    pronto_saida = 1'b1;
    espera_idle("bp_timeout");
    @(posedge clk); #1;
    verifica("bp_fim_count", 32'(fim_cnt - base_fim), 32'd1);
    verifica("bp_drain", 32'(q_esp.size()), 32'd0);

    // Store update and a second request during a readout are both ignored.
    base_fim = fim_cnt;
    Matricula1 = 24'h12AB34; Matricula2 = 24'h56CD78;
    empilha_par(Matricula1, Matricula2);
    pulso_pedido();
    espera_pos(1'b0, 3'd2, "snap_reach_timeout");
    Matricula1 = 24'h999999;
    pulso_pedido();
    espera_idle("snap_timeout");
    repeat (3) @(posedge clk);
    #1;
    verifica("snap_fim_count", 32'(fim_cnt - base_fim), 32'd1);
    verifica("snap_drain", 32'(q_esp.size()), 32'd0);
    verifica("snap_stays_idle", {31'd0, ocupado}, 32'd0);

    // Reset mid-readout after the 4th transfer.
    base_fim = fim_cnt;
    Matricula1 = 24'h12AB34;
    empilha_par(Matricula1, Matricula2);
    pulso_pedido();
    espera_pos(1'b0, 3'd4, "rst_reach_timeout");
    rst_n = 1'b0;
    #1;
    verifica("async_reset_outputs",
             {20'd0, digito, digito_valido, indice, posicao, ultimo, ocupado, fim, vazio}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    verifica("post_reset_idle", {30'd0, ocupado, digito_valido}, 32'd0);
    verifica("rst_no_fim", 32'(fim_cnt - base_fim), 32'd0);
    leitura(24'h12AB34, 24'h56CD78, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
